// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared state type and parameter defaults for the core clock-enable controller
package cpu_clk_pkg;

    localparam int DIV_W_DEFAULT   = 8;
    localparam int DEF_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/clk_phase_counter.sv
// rtl/clk_phase_counter.sv - wrapping phase counter with a registered look-ahead terminal flag
module clk_phase_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] limit,
    output logic         terminal,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (clear) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = terminal ? '0 : cnt + 1'b1;
        end
    end

    // limit is the divisor that will be in force next cycle, so terminal
    // rises together with cnt reaching limit-1 instead of one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            terminal <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            terminal <= !clear && (cnt_d == limit - 1'b1);
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - run/step/drain clock-enable generator with glitch-free divisor reload
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    input  logic             run_req,
    input  logic             step_req,
    output logic             cpu_en,
    output logic             div_ack,
    output logic             halted,
    output logic [31:0]      en_count
);

    localparam int DEF_EFF = (DEF_DIV < 2) ? 1 : DEF_DIV;

    logic [1:0]       rst_pipe;
    logic             rst_core_n;
    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] div_eff_n;
    logic [DIV_W-1:0] shadow_val;
    logic             shadow_valid;
    logic [DIV_W-1:0] ld_val;
    logic [DIV_W-1:0] ld_norm;
    logic             ld_valid;
    logic             boundary;
    logic             apply;
    logic             terminal;
    logic [DIV_W-1:0] cnt;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end
    assign rst_core_n = rst_pipe[1];

    always_comb begin
        state_n = state;
        case (state)
            ST_HALT: begin
                if (run_req) begin
                    state_n = ST_RUN;
                end else if (step_req) begin
                    state_n = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!run_req) begin
                    state_n = terminal ? ST_HALT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (run_req) begin
                    state_n = ST_RUN;
                end else if (terminal) begin
                    state_n = ST_HALT;
                end
            end
            ST_STEP: begin
                if (terminal) begin
                    state_n = ST_HALT;
                end
            end
            default: state_n = ST_HALT;
        endcase
    end

    // A divisor loaded in the boundary cycle itself takes that boundary.
    always_comb begin
        ld_valid  = div_load | shadow_valid;
        ld_val    = div_load ? div_val : shadow_val;
        ld_norm   = (ld_val < DIV_W'(2)) ? DIV_W'(1) : ld_val;
        boundary  = (state != ST_HALT) && (cnt == div_eff - 1'b1);
        apply     = ld_valid && ((state == ST_HALT) || boundary);
        div_eff_n = apply ? ld_norm : div_eff;
    end

    clk_phase_counter #(
        .W(DIV_W)
    ) u_phase (
        .clk      (clk),
        .rst_n    (rst_core_n),
        .clear    (state_n == ST_HALT),
        .advance  (state != ST_HALT),
        .limit    (div_eff_n),
        .terminal (terminal),
        .cnt      (cnt)
    );

    assign cpu_en = terminal;

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state        <= ST_HALT;
            halted       <= 1'b1;
            div_eff      <= DIV_W'(DEF_EFF);
            shadow_val   <= '0;
            shadow_valid <= 1'b0;
            div_ack      <= 1'b0;
            en_count     <= '0;
        end else begin
            state        <= state_n;
            halted       <= (state_n == ST_HALT);
            div_eff      <= div_eff_n;
            shadow_val   <= ld_val;
            shadow_valid <= ld_valid && !apply;
            div_ack      <= apply;
            en_count     <= en_count + 32'(terminal);
        end
    end

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the divisor value.
REQ-002 SHALL have parameter DEF_DIV, default 4, divisor in effect after reset (100 MHz clk to 25 MHz core rate).
REQ-003 SHALL have port clk  input  1  free-running 100 MHz board clock; the only clock of the block.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port div_val  input  DIV_W  requested divisor.
REQ-006 SHALL have port div_load  input  1  one-cycle strobe that captures div_val.
REQ-007 SHALL have port run_req  input  1  level; request free-running mode.
REQ-008 SHALL have port step_req  input  1  one-cycle strobe; request exactly one core enable.
REQ-009 SHALL have port cpu_en  output  1  clock-enable strobe for every core register; high for one clk cycle.
REQ-010 SHALL have port div_ack  output  1  one-cycle pulse when a loaded divisor takes effect.
REQ-011 SHALL have port halted  output  1  high while state is HALT.
REQ-012 SHALL have port en_count  output  32  count of cpu_en pulses issued since reset.

Function
REQ-013 SHALL implement states HALT, RUN, STEP, DRAIN.
REQ-014 SHALL keep a phase counter cnt (DIV_W bits) that counts 0..div_eff-1 and wraps to 0; it advances only in RUN, STEP and DRAIN.
REQ-015 SHALL assert cpu_en only when cnt == div_eff-1 in RUN, STEP or DRAIN; no gated or derived clocks are produced.
REQ-016 SHALL treat div_val of 0 or 1 as divisor 1, so cpu_en is high on every clk cycle while running.
REQ-017 SHALL hold div_load data in a shadow register and apply it only at a period boundary (the cycle cpu_en is high) or immediately while in HALT, pulsing div_ack in the cycle after it applies.
REQ-018 SHALL keep only the last value when div_load repeats before the value applies; one div_ack is issued.
REQ-019 Transitions:
- HALT to RUN when run_req=1.
- HALT to STEP when step_req=1 and run_req=0.
- RUN to DRAIN when run_req falls.
- DRAIN to HALT in the cycle after the cpu_en that closes the current period.
- STEP to HALT in the cycle after its single cpu_en.
REQ-020 SHALL ignore step_req outside HALT; run_req has priority over step_req in HALT.
REQ-021 SHALL return to RUN from DRAIN when run_req rises again, with no lost or extra pulse and cnt not reset.
REQ-022 SHALL clear cnt to 0 on entry to HALT, so the first pulse after leaving HALT comes div_eff cycles later.
REQ-023 SHALL increment en_count by 1 per cpu_en, wrapping 0xFFFFFFFF to 0.
REQ-024 SHALL register all outputs; halted SHALL reflect the state register.

Reset
REQ-025 On rst_n=0, SHALL set state HALT, cnt 0, div_eff = DEF_DIV, shadow empty, cpu_en 0, div_ack 0, halted 1, en_count 0.
REQ-026 Reset mid-period SHALL abort without any further cpu_en; a pending divisor SHALL be discarded.
REQ-027 SHALL make rst_n assertion asynchronous and have the reset-removal point registered on clk.

Structure
REQ-028 SHALL place the state enum type and the DEF_DIV and DIV_W defaults in shared package cpu_clk_pkg.
REQ-029 SHALL implement the phase counter as sub-module clk_phase_counter (inputs: clear, advance, limit; outputs: terminal, cnt); the FSM stays in cpu_clk_ctrl.

Verification
REQ-030 Reset then run_req=1 with DEF_DIV=4 -> first cpu_en 4 cycles after entering RUN, then every 4th cycle; halted=0.
REQ-031 In RUN with div 4, div_load of div_val=2 at cnt=1 -> remaining pulse still at cnt=3; div_ack next cycle; then pulses every 2 cycles.
REQ-032 In HALT, step_req pulse with div 4 -> exactly one cpu_en 4 cycles later, then HALT; en_count +1.
REQ-033 run_req dropped at cnt=0 -> pulse at cnt=3, then HALT; run_req reasserted in DRAIN -> continuous pulse spacing of 4.
REQ-034 div_val=0 -> cpu_en high every cycle while RUN; rst_n low mid-period -> cpu_en 0 and halted 1 immediately, en_count 0.
REQ-035 en_count preloaded by force to 0xFFFFFFFE, 2 pulses -> reads 0x00000000.
